// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer drain controller: FSM encoding,
// the store entry record and default sizing constants.
package sb_pkg;

  localparam int SB_DEPTH_DEF  = 4;
  localparam int SB_ADDR_W_DEF = 32;
  localparam int SB_DATA_W_DEF = 32;
  localparam int SB_STRB_W_DEF = SB_DATA_W_DEF / 8;

  // Drain FSM: IDLE waits for work, ISSUE presents the head entry,
  // WAIT_ACK holds the single outstanding write until memory completes it.
  typedef enum logic [1:0] {
    SB_IDLE     = 2'd0,
    SB_ISSUE    = 2'd1,
    SB_WAIT_ACK = 2'd2
  } sb_state_e;

  // One buffered store at the default widths.
  typedef struct packed {
    logic [SB_ADDR_W_DEF-1:0] addr;
    logic [SB_DATA_W_DEF-1:0] data;
    logic [SB_STRB_W_DEF-1:0] strb;
  } sb_entry_t;

endpackage

// File: rtl/storebuffer_fifo.sv
// In-order store FIFO: storage, wrap-bit pointers, full/count and the head
// read port. With STOREBUFFER_LOAD_HAZARD_EN defined it also exposes every
// slot's address/strobe and a per-slot valid mask for load probing.
module storebuffer_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEF,
  parameter int ADDR_W = SB_ADDR_W_DEF,
  parameter int DATA_W = SB_DATA_W_DEF,
  parameter int STRB_W = DATA_W / 8,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [STRB_W-1:0] push_strb_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic [CW-1:0]     count_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [STRB_W-1:0] head_strb_o
`ifdef STOREBUFFER_LOAD_HAZARD_EN
  ,
  output logic [ADDR_W-1:0] ent_addr_o [DEPTH],
  output logic [STRB_W-1:0] ent_strb_o [DEPTH],
  output logic [DEPTH-1:0]  ent_valid_o
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]       head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [STRB_W-1:0] strb_mem [DEPTH];

  // Pointer advance: tail on push, head on pop; the extra top bit is the wrap flag.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage is written at the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem[tail_q[IW-1:0]] <= push_addr_i;
      data_mem[tail_q[IW-1:0]] <= push_data_i;
      strb_mem[tail_q[IW-1:0]] <= push_strb_i;
    end
  end

  assign full_o  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign count_o = tail_q - head_q;

  assign head_addr_o = addr_mem[head_q[IW-1:0]];
  assign head_data_o = data_mem[head_q[IW-1:0]];
  assign head_strb_o = strb_mem[head_q[IW-1:0]];

`ifdef STOREBUFFER_LOAD_HAZARD_EN
  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_probe
    logic [IW-1:0] dist;
    assign dist           = IW'(g) - head_q[IW-1:0];
    assign ent_valid_o[g] = ({1'b0, dist} < count_o);
    assign ent_addr_o[g]  = addr_mem[g];
    assign ent_strb_o[g]  = strb_mem[g];
  end
`endif

endmodule

// File: rtl/storebuffer_drain_ctrl.sv
// Store buffer drain controller: queues committed stores and writes them to
// the data memory one at a time (valid/ready request, separate ack pulse).
// Provides fence sequencing with a one-cycle completion pulse.
// Optional load-address hazard probe: define STOREBUFFER_LOAD_HAZARD_EN.
//
// Handshakes: a push is taken on a cycle with push_valid & push_ready; a
// memory request is taken on a cycle with mem_req_valid & mem_req_ready, and
// mem_req_addr/data/strb stay stable while mem_req_valid is held waiting.
// mem_ack is honoured only while the single accepted write is outstanding.
module storebuffer_drain_ctrl
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEF,
  parameter int ADDR_W = SB_ADDR_W_DEF,
  parameter int DATA_W = SB_DATA_W_DEF,
  localparam int STRB_W = DATA_W / 8,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [STRB_W-1:0] push_strb,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [STRB_W-1:0] mem_req_strb,
  input  logic              mem_ack,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              sb_empty,
  output logic [CW-1:0]     sb_count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit
);

  // state_q is the observable FSM state for checkers.
  sb_state_e state_q, state_d;
  logic      fence_pending_q, fence_pending_d;
  logic      full, push_fire, pop;

`ifdef STOREBUFFER_LOAD_HAZARD_EN
  logic [ADDR_W-1:0] ent_addr  [DEPTH];
  logic [STRB_W-1:0] ent_strb  [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
`endif

  assign push_ready = ~full;
  assign push_fire  = push_valid & ~full;
  assign pop        = (state_q == SB_WAIT_ACK) & mem_ack;

  storebuffer_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STRB_W(STRB_W),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push_fire),
    .push_addr_i(push_addr),
    .push_data_i(push_data),
    .push_strb_i(push_strb),
    .pop_i      (pop),
    .full_o     (full),
    .count_o    (sb_count),
    .head_addr_o(mem_req_addr),
    .head_data_o(mem_req_data),
    .head_strb_o(mem_req_strb)
`ifdef STOREBUFFER_LOAD_HAZARD_EN
    ,
    .ent_addr_o (ent_addr),
    .ent_strb_o (ent_strb),
    .ent_valid_o(ent_valid)
`endif
  );

  // Drain FSM next state and request valid; the head stays queued until its ack.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (sb_count != '0) state_d = SB_ISSUE;
      end
      SB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = SB_WAIT_ACK;
      end
      SB_WAIT_ACK: begin
        // Entries left after this pop, including a same-cycle push, go straight to ISSUE.
        if (mem_ack) state_d = ((sb_count > CW'(1)) || push_fire) ? SB_ISSUE : SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  assign sb_empty   = (sb_count == '0) && (state_q == SB_IDLE);
  assign fence_done = fence_pending_q & sb_empty;

  // A fence stays pending until the first fully drained cycle; repeats are absorbed.
  always_comb begin
    fence_pending_d = fence_pending_q | fence_req;
    if (fence_done) fence_pending_d = 1'b0;
  end

  // FSM and fence registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= SB_IDLE;
      fence_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fence_pending_q <= fence_pending_d;
    end
  end

`ifdef STOREBUFFER_LOAD_HAZARD_EN
  localparam int OFF_W = $clog2(STRB_W);

  // Word-granular overlap of the load address against every live store with any byte enabled.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_strb[i] != '0) &&
          ((ent_addr[i] >> OFF_W) == (ld_addr >> OFF_W)))
        ld_hit = 1'b1;
    end
  end
`else
  assign ld_hit = 1'b0;
  logic unused_ld_addr;
  assign unused_ld_addr = &{1'b0, ld_addr};
`endif

endmodule

// File: tb/tb_storebuffer_drain_ctrl.sv
// Bench for storebuffer_drain_ctrl: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_storebuffer_drain_ctrl;
  import sb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_strb;
  logic        mem_ack;
  logic        fence_req;
  logic        fence_done;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic [31:0] ld_addr;
  logic        ld_hit;

  int n_pass  = 0;
  int n_total = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  storebuffer_drain_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data), .push_strb(push_strb),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb),
    .mem_ack(mem_ack), .fence_req(fence_req), .fence_done(fence_done),
    .sb_empty(sb_empty), .sb_count(sb_count), .ld_addr(ld_addr), .ld_hit(ld_hit)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_addr = 0; push_data = 0; push_strb = 0;
    mem_req_ready = 0; mem_ack = 0; fence_req = 0; ld_addr = 0;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    push_valid = 1; push_addr = a; push_data = d; push_strb = s;
    step();
    push_valid = 0;
  endtask

  // Accept every request and ack the cycle after, until the buffer is empty.
  task automatic drain();
    bit w;
    w = 0; push_valid = 0; fence_req = 0; mem_req_ready = 1;
    for (int c = 0; c < 100 && !(sb_empty && !w); c++) begin
      mem_ack = w;
      #1;
      if (mem_ack) w = 0;
      else if (mem_req_valid) w = 1;
      step();
    end
    mem_ack = 0; mem_req_ready = 0;
    #1;
    chk("drain_done", sb_empty, 1);
    step();
  endtask

  typedef struct {
    logic        pv; logic [31:0] pa; logic [31:0] pd; logic [3:0] ps;
    logic        rdy; logic ack; logic fen;
    logic        e_val; logic e_prdy; logic [2:0] e_cnt; logic e_emp; logic e_fd;
    logic [31:0] e_addr; logic [31:0] e_data; logic [3:0] e_strb;
  } vec_t;

  vec_t vt[9];

  // Reference model state for the random run.
  sb_entry_t mq[$];
  bit outst, pend;
  int dly, cyc, elig;

  initial begin
    bit w, seen;
    int got, acks, pulses, ack3, fdc, d;

    // Single store then a fence on the drained buffer.
    vt[0] = '{1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 3'd1, 0, 0, 0, 0, 0};
    vt[2] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 3'd1, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF};
    vt[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 0, 0};
    vt[5] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd1, 0, 0, 0, 0, 0};
    vt[6] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 3'd0, 1, 0, 0, 0, 0};
    vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 0};
    vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0};

    // Reset block.
    idle_inputs();
    resetn = 0;
    step();
    #1;
    chk("rst_push_ready", push_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_fence_done", fence_done, 0);
    chk("rst_empty", sb_empty, 1);
    chk("rst_count", sb_count, 0);
    chk("rst_ld_hit", ld_hit, 0);
    step();
    resetn = 1;
    step();

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      push_valid = vt[i].pv; push_addr = vt[i].pa; push_data = vt[i].pd; push_strb = vt[i].ps;
      mem_req_ready = vt[i].rdy; mem_ack = vt[i].ack; fence_req = vt[i].fen;
      #1;
      chk($sformatf("vec%0d_req_valid", i), mem_req_valid, vt[i].e_val);
      chk($sformatf("vec%0d_push_ready", i), push_ready, vt[i].e_prdy);
      chk($sformatf("vec%0d_count", i), sb_count, vt[i].e_cnt);
      chk($sformatf("vec%0d_empty", i), sb_empty, vt[i].e_emp);
      chk($sformatf("vec%0d_fence_done", i), fence_done, vt[i].e_fd);
      if (vt[i].e_val) begin
        chk($sformatf("vec%0d_addr", i), mem_req_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_data", i), mem_req_data, vt[i].e_data);
        chk($sformatf("vec%0d_strb", i), mem_req_strb, vt[i].e_strb);
      end
      step();
    end
    idle_inputs();
    step();

    // Fill to full with memory stalled, then drain in order.
    for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(i * 16), 32'hA0 + 32'(i), 4'hF);
    #1;
    chk("fill_count", sb_count, 4);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_req_valid", mem_req_valid, 1);
    chk("fill_head_addr", mem_req_addr, 32'h1000);
    step();
    mem_req_ready = 1; w = 0; got = 0; acks = 0; seen = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      mem_ack = w;
      #1;
      if (acks == 1 && !seen) begin
        chk("fill_push_ready_after_ack", push_ready, 1);
        seen = 1;
      end
      if (mem_req_valid) begin
        chk("fill_order_addr", mem_req_addr, 32'h1000 + 32'(got * 16));
        chk("fill_order_data", mem_req_data, 32'hA0 + 32'(got));
        got++; w = 1;
      end
      if (mem_ack) begin acks++; w = 0; end
      step();
    end
    mem_ack = 0; mem_req_ready = 0;
    chk("fill_ack_count", acks, 4);
    drain();

    // Push and ack in the same cycle at count 2.
    push_one(32'h2000, 32'h11, 4'h3);
    push_one(32'h2010, 32'h22, 4'hC);
    mem_req_ready = 1;
    #1;
    chk("simul_first_req", mem_req_addr, 32'h2000);
    step();
    mem_req_ready = 0; mem_ack = 1;
    push_valid = 1; push_addr = 32'h2020; push_data = 32'h33; push_strb = 4'hF;
    #1;
    chk("simul_count_before", sb_count, 2);
    step();
    push_valid = 0; mem_ack = 0;
    #1;
    chk("simul_count_after", sb_count, 2);
    chk("simul_next_valid", mem_req_valid, 1);
    chk("simul_next_addr", mem_req_addr, 32'h2010);
    chk("simul_next_strb", mem_req_strb, 4'hC);
    step();
    drain();

    // Fence over three queued entries, acks two cycles after acceptance.
    push_one(32'h3000, 1, 4'hF);
    push_one(32'h3004, 2, 4'hF);
    push_one(32'h3008, 3, 4'hF);
    fence_req = 1; mem_req_ready = 1;
    w = 0; d = 0; acks = 0; pulses = 0; ack3 = -1; fdc = -1;
    for (int c = 0; c < 60; c++) begin
      mem_ack = w && (d == 0);
      #1;
      if (fence_done) begin pulses++; fdc = c; end
      if (mem_ack) begin
        acks++; w = 0;
        if (acks == 3) ack3 = c;
      end else if (w) d--;
      else if (mem_req_valid) begin w = 1; d = 1; end
      step();
      fence_req = 0;
    end
    mem_ack = 0; mem_req_ready = 0;
    chk("fence3_acks", acks, 3);
    chk("fence3_pulses", pulses, 1);
    chk("fence3_pulse_cycle", fdc, ack3 + 1);

    // Fence on an already empty buffer.
    fence_req = 1;
    #1;
    chk("fence_empty_same", fence_done, 0);
    step();
    fence_req = 0;
    #1;
    chk("fence_empty_next", fence_done, 1);
    step();
    #1;
    chk("fence_empty_after", fence_done, 0);
    step();

    // Reset while a write is outstanding with a fence pending.
    push_one(32'h4000, 5, 4'hF);
    push_one(32'h4004, 6, 4'hF);
    mem_req_ready = 1; fence_req = 1;
    #1;
    chk("rstmid_issue", mem_req_valid, 1);
    step();
    mem_req_ready = 0; fence_req = 0; resetn = 0;
    step();
    #1;
    chk("rstmid_count", sb_count, 0);
    chk("rstmid_req_valid", mem_req_valid, 0);
    chk("rstmid_fence_done", fence_done, 0);
    chk("rstmid_empty", sb_empty, 1);
    resetn = 1;
    step();
    #1;
    chk("rstmid_fence_cleared", fence_done, 0);
    step();

`ifdef STOREBUFFER_LOAD_HAZARD_EN
    // Load probe against a single buffered byte store.
    push_one(32'h204, 32'h5A, 4'h1);
    ld_addr = 32'h206;
    #1;
    chk("haz_same_word", ld_hit, 1);
    step();
    ld_addr = 32'h208;
    #1;
    chk("haz_next_word", ld_hit, 0);
    step();
    ld_addr = 32'h206;
    drain();
    #1;
    chk("haz_after_ack", ld_hit, 0);
    step();
`endif

    // Randomized run against the queue model.
    idle_inputs();
    mq.delete(); outst = 0; pend = 0; dly = 0; cyc = 0; elig = 0;
    for (int n = 0; n < 500; n++) begin
      bit ev, efd, ehit, push_fire, ack_fire, req_fire;
      int size_before;
      efd = pend && (mq.size() == 0);
      ev  = (mq.size() > 0) && !outst && (cyc >= elig);
      push_valid    = ($urandom_range(0, 2) != 0);
      push_addr     = 32'h200 + 32'($urandom_range(0, 31));
      push_data     = $urandom();
      push_strb     = 4'($urandom_range(0, 15));
      mem_req_ready = ($urandom_range(0, 1) == 1);
      mem_ack       = outst ? (dly == 0) : ($urandom_range(0, 7) == 0);
      fence_req     = !efd && ($urandom_range(0, 15) == 0);
      ld_addr       = 32'h200 + 32'($urandom_range(0, 31));
      #1;
      ehit = 0;
`ifdef STOREBUFFER_LOAD_HAZARD_EN
      foreach (mq[k])
        if (mq[k].addr[31:2] == ld_addr[31:2] && mq[k].strb != 0) ehit = 1;
`endif
      chk("rnd_count", sb_count, mq.size());
      chk("rnd_push_ready", push_ready, mq.size() < DEPTH);
      chk("rnd_empty", sb_empty, mq.size() == 0);
      chk("rnd_req_valid", mem_req_valid, ev);
      chk("rnd_fence_done", fence_done, efd);
      chk("rnd_ld_hit", ld_hit, ehit);
      if (ev) begin
        chk("rnd_req_addr", mem_req_addr, mq[0].addr);
        chk("rnd_req_data", mem_req_data, mq[0].data);
        chk("rnd_req_strb", mem_req_strb, mq[0].strb);
      end
      size_before = mq.size();
      push_fire = push_valid && (size_before < DEPTH);
      ack_fire  = outst && mem_ack;
      req_fire  = ev && mem_req_ready;
      if (efd) pend = 0;
      else if (fence_req) pend = 1;
      if (ack_fire) begin
        void'(mq.pop_front());
        outst = 0;
      end else if (outst) dly--;
      if (req_fire) begin
        outst = 1;
        dly = $urandom_range(0, 3);
      end
      if (push_fire) begin
        if (size_before == 0) elig = cyc + 2;
        mq.push_back('{addr: push_addr, data: push_data, strb: push_strb});
      end
      if (ack_fire && mq.size() > 0) elig = cyc + 1;
      cyc++;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
